controle_partida: RTL and testbench



---
 rtl/controle_partida.sv | 154 +++++++++++++++
 tb/tb_controle_partida.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/controle_partida.sv
// rtl/controle_partida.sv - match-level sequencer driving simulador_drone rounds
//
// Owns lives and difficulty level. Programs the per-level wait period and fires one
// iniciar pulse per round. Tallies round outcomes and ends the match as champion or
// game over.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   jogar          in   start / restart request
//   venceu_rodada  in   simulator round-won level
//   perdeu_rodada  in   simulator round-lost level
//   iniciar_rodada out  one-cycle round start pulse
//   periodo_espera out  wait period for the current level (registered)
//   nivel          out  current level, 0-based
//   vidas          out  remaining lives
//   campeao        out  high while in CAMPEAO
//   fim_jogo       out  high while in DERROTA
//   db_estado      out  state code for debug display
module controle_partida #(
    parameter int NUM_VIDAS    = 3,
    parameter int NUM_NIVEIS   = 4,
    parameter int T_BASE       = 50,
    parameter int T_PASSO      = 10,
    parameter int PAUSA_CICLOS = 100,
    parameter int W_T          = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           jogar,
    input  logic           venceu_rodada,
    input  logic           perdeu_rodada,
    output logic           iniciar_rodada,
    output logic [W_T-1:0] periodo_espera,
    output logic [1:0]     nivel,
    output logic [1:0]     vidas,
    output logic           campeao,
    output logic           fim_jogo,
    output logic [3:0]     db_estado
);

    localparam int         CW        = $clog2(PAUSA_CICLOS + 1);
    localparam logic [1:0] NIVEL_MAX = 2'(NUM_NIVEIS - 1);
    localparam logic [1:0] VIDAS_INI = 2'(NUM_VIDAS);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        PREPARA = 4'd1,
        DISPARA = 4'd2,
        JOGANDO = 4'd3,
        ACERTO  = 4'd4,
        ERRO    = 4'd5,
        PAUSA   = 4'd6,
        CAMPEAO = 4'd7,
        DERROTA = 4'd8
    } estado_t;

    estado_t        estado, estado_prox;
    logic [1:0]     nivel_prox, vidas_prox;
    logic [W_T-1:0] periodo_prox;
    logic [CW-1:0]  cont, cont_prox;
    logic           prev_v, prev_p;
    logic           ev_v, ev_p;

    // Rising edges only: a level held high by the simulator counts once.
    assign ev_v = venceu_rodada & ~prev_v;
    assign ev_p = perdeu_rodada & ~prev_p;

    // Period shrinks with level but saturates at 1 so the datapath never stalls or wraps.
    logic [31:0]    reducao;
    logic [W_T-1:0] periodo_nivel;
    assign reducao       = 32'(nivel) * 32'(T_PASSO);
    assign periodo_nivel = (reducao >= 32'(T_BASE)) ? W_T'(1) : W_T'(32'(T_BASE) - reducao);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado         <= OCIOSO;
            nivel          <= 2'd0;
            vidas          <= 2'd0;
            periodo_espera <= W_T'(T_BASE);
            cont           <= '0;
            prev_v         <= 1'b0;
            prev_p         <= 1'b0;
        end else begin
            estado         <= estado_prox;
            nivel          <= nivel_prox;
            vidas          <= vidas_prox;
            periodo_espera <= periodo_prox;
            cont           <= cont_prox;
            prev_v         <= venceu_rodada;
            prev_p         <= perdeu_rodada;
        end
    end

    always_comb begin
        estado_prox  = estado;
        nivel_prox   = nivel;
        vidas_prox   = vidas;
        periodo_prox = periodo_espera;
        cont_prox    = cont;
        case (estado)
            OCIOSO, CAMPEAO, DERROTA: begin
                if (jogar) begin
                    vidas_prox  = VIDAS_INI;
                    nivel_prox  = 2'd0;
                    estado_prox = PREPARA;
                end
            end
            PREPARA: begin
                periodo_prox = periodo_nivel;
                estado_prox  = DISPARA;
            end
            DISPARA: estado_prox = JOGANDO;
            JOGANDO: begin
                // A loss edge takes priority over a simultaneous win edge.
                if (ev_p)      estado_prox = ERRO;
                else if (ev_v) estado_prox = ACERTO;
            end
            ACERTO: begin
                if (nivel == NIVEL_MAX) begin
                    estado_prox = CAMPEAO;
                end else begin
                    nivel_prox  = nivel + 2'd1;
                    cont_prox   = '0;
                    estado_prox = PAUSA;
                end
            end
            ERRO: begin
                if (vidas <= 2'd1) begin
                    vidas_prox  = 2'd0;
                    estado_prox = DERROTA;
                end else begin
                    vidas_prox  = vidas - 2'd1;
                    cont_prox   = '0;
                    estado_prox = PAUSA;
                end
            end
            PAUSA: begin
                if (cont == CW'(PAUSA_CICLOS - 1)) begin
                    estado_prox = PREPARA;
                end else begin
                    cont_prox = cont + CW'(1);
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    assign iniciar_rodada = (estado == DISPARA);
    assign campeao        = (estado == CAMPEAO);
    assign fim_jogo       = (estado == DERROTA);
    assign db_estado      = estado;

endmodule

// File: tb/tb_controle_partida.sv
// tb/tb_controle_partida.sv - directed self-checking bench for controle_partida
module tb_controle_partida;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar, venceu, perdeu;
    logic       iniciar;
    logic [7:0] periodo;
    logic [1:0] nivel, vidas;
    logic       campeao, fim_jogo;
    logic [3:0] db_estado;

    logic       jogar_b, venceu_b, perdeu_b;
    logic       iniciar_b;
    logic [7:0] periodo_b;
    logic [1:0] nivel_b, vidas_b;
    logic       campeao_b, fim_jogo_b;
    logic [3:0] db_estado_b;

    int checks = 0;
    int errors = 0;
    int ini_a  = 0;

    always #5 clock = ~clock;

    // Pulse observed at the rising edge that ends the DISPARA cycle.
    always @(posedge clock) begin
        if (iniciar === 1'b1) ini_a++;
    end

    controle_partida dut (
        .clock(clock), .reset(reset), .jogar(jogar),
        .venceu_rodada(venceu), .perdeu_rodada(perdeu),
        .iniciar_rodada(iniciar), .periodo_espera(periodo),
        .nivel(nivel), .vidas(vidas), .campeao(campeao),
        .fim_jogo(fim_jogo), .db_estado(db_estado)
    );

    controle_partida #(.T_PASSO(30), .PAUSA_CICLOS(2)) dut_b (
        .clock(clock), .reset(reset), .jogar(jogar_b),
        .venceu_rodada(venceu_b), .perdeu_rodada(perdeu_b),
        .iniciar_rodada(iniciar_b), .periodo_espera(periodo_b),
        .nivel(nivel_b), .vidas(vidas_b), .campeao(campeao_b),
        .fim_jogo(fim_jogo_b), .db_estado(db_estado_b)
    );

    task automatic wait_ini(input bit use_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if ((use_b ? iniciar_b : iniciar) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; jogar = 0; venceu = 0; perdeu = 0;
        jogar_b = 0; venceu_b = 0; perdeu_b = 0;
        #3 reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", db_estado); end
        checks++; if (vidas !== 2'd0 || nivel !== 2'd0) begin errors++; $display("FAIL reset_vidas_nivel: got %0d/%0d expected 0/0", vidas, nivel); end
        checks++; if (periodo !== 8'd50) begin errors++; $display("FAIL reset_periodo: got %0d expected 50", periodo); end
        checks++; if (iniciar !== 1'b0 || campeao !== 1'b0 || fim_jogo !== 1'b0) begin errors++; $display("FAIL reset_flags: got %0b%0b%0b expected 000", iniciar, campeao, fim_jogo); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_win;
        bit ok;
        int exp_p [4] = '{50, 40, 30, 20};
        jogar = 1; @(negedge clock); jogar = 0;
        checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL win_prepara: got %0d expected 1", db_estado); end
        @(negedge clock);
        checks++; if (iniciar !== 1'b1) begin errors++; $display("FAIL win_latency: got %0b expected 1", iniciar); end
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                wait_ini(1'b0, ok);
                checks++; if (!ok) begin errors++; $display("FAIL win_timeout: round %0d got no pulse expected pulse", r); end
            end
            checks++; if (periodo !== 8'(exp_p[r])) begin errors++; $display("FAIL win_periodo: round %0d got %0d expected %0d", r, periodo, exp_p[r]); end
            @(negedge clock);
            venceu = 1; @(negedge clock); venceu = 0;
        end
        @(negedge clock);
        checks++; if (campeao !== 1'b1 || db_estado !== 4'd7) begin errors++; $display("FAIL win_campeao: got %0b/%0d expected 1/7", campeao, db_estado); end
        checks++; if (nivel !== 2'd3 || vidas !== 2'd3) begin errors++; $display("FAIL win_nivel_vidas: got %0d/%0d expected 3/3", nivel, vidas); end
        repeat (3) @(negedge clock);
        checks++; if (periodo !== 8'd20 || campeao !== 1'b1) begin errors++; $display("FAIL win_frozen: got %0d/%0b expected 20/1", periodo, campeao); end
    endtask

    task automatic test_loss;
        bit ok;
        int base;
        base = ini_a;
        jogar = 1; @(negedge clock); jogar = 0;
        checks++; if (campeao !== 1'b0) begin errors++; $display("FAIL loss_flag_clear: got %0b expected 0", campeao); end
        for (int r = 0; r < 3; r++) begin
            wait_ini(1'b0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL loss_timeout: round %0d got no pulse expected pulse", r); end
            if (r == 0) begin
                checks++; if (vidas !== 2'd3 || nivel !== 2'd0) begin errors++; $display("FAIL loss_start: got %0d/%0d expected 3/0", vidas, nivel); end
            end
            @(negedge clock);
            perdeu = 1; @(negedge clock);
            checks++; if (db_estado !== 4'd5) begin errors++; $display("FAIL loss_erro: got %0d expected 5", db_estado); end
            perdeu = 0; @(negedge clock);
            checks++; if (vidas !== 2'(2 - r)) begin errors++; $display("FAIL loss_vidas: round %0d got %0d expected %0d", r, vidas, 2 - r); end
        end
        checks++; if (fim_jogo !== 1'b1 || db_estado !== 4'd8) begin errors++; $display("FAIL loss_derrota: got %0b/%0d expected 1/8", fim_jogo, db_estado); end
        repeat (150) @(negedge clock);
        checks++; if (ini_a - base !== 3) begin errors++; $display("FAIL loss_pulses: got %0d expected 3", ini_a - base); end
        checks++; if (vidas !== 2'd0 || fim_jogo !== 1'b1) begin errors++; $display("FAIL loss_frozen: got %0d/%0b expected 0/1", vidas, fim_jogo); end
    endtask

    task automatic test_restart;
        jogar = 1; @(negedge clock); jogar = 0;
        checks++; if (fim_jogo !== 1'b0) begin errors++; $display("FAIL restart_flag: got %0b expected 0", fim_jogo); end
        checks++; if (vidas !== 2'd3 || nivel !== 2'd0) begin errors++; $display("FAIL restart_load: got %0d/%0d expected 3/0", vidas, nivel); end
        checks++; if (iniciar !== 1'b0) begin errors++; $display("FAIL restart_early: got %0b expected 0", iniciar); end
        @(negedge clock);
        checks++; if (iniciar !== 1'b1) begin errors++; $display("FAIL restart_latency: got %0b expected 1", iniciar); end
    endtask

    task automatic test_same_cycle;
        @(negedge clock);
        venceu = 1; perdeu = 1; @(negedge clock);
        checks++; if (db_estado !== 4'd5) begin errors++; $display("FAIL same_erro: got %0d expected 5", db_estado); end
        venceu = 0; perdeu = 0; @(negedge clock);
        checks++; if (vidas !== 2'd2 || nivel !== 2'd0 || db_estado !== 4'd6) begin errors++; $display("FAIL same_result: got %0d/%0d/%0d expected 2/0/6", vidas, nivel, db_estado); end
    endtask

    task automatic test_held_venceu;
        bit ok;
        wait_ini(1'b0, ok);
        checks++; if (!ok || periodo !== 8'd50) begin errors++; $display("FAIL held_first: got %0b/%0d expected 1/50", ok, periodo); end
        @(negedge clock);
        venceu = 1; @(negedge clock);
        wait_ini(1'b0, ok);
        checks++; if (!ok || periodo !== 8'd40) begin errors++; $display("FAIL held_second: got %0b/%0d expected 1/40", ok, periodo); end
        @(negedge clock);
        repeat (5) @(negedge clock);
        checks++; if (db_estado !== 4'd3 || nivel !== 2'd1) begin errors++; $display("FAIL held_once: got %0d/%0d expected 3/1", db_estado, nivel); end
        venceu = 0; @(negedge clock);
        venceu = 1; @(negedge clock);
        checks++; if (db_estado !== 4'd4) begin errors++; $display("FAIL held_new_edge: got %0d expected 4", db_estado); end
        venceu = 0; @(negedge clock);
        checks++; if (nivel !== 2'd2 || db_estado !== 4'd6) begin errors++; $display("FAIL held_advance: got %0d/%0d expected 2/6", nivel, db_estado); end
    endtask

    task automatic test_jogar_and_reset;
        bit ok;
        int base;
        wait_ini(1'b0, ok);
        checks++; if (!ok || periodo !== 8'd30) begin errors++; $display("FAIL mid_periodo: got %0b/%0d expected 1/30", ok, periodo); end
        @(negedge clock);
        base = ini_a;
        jogar = 1; @(negedge clock); jogar = 0;
        repeat (4) @(negedge clock);
        checks++; if (db_estado !== 4'd3 || ini_a !== base) begin errors++; $display("FAIL mid_jogar_ignored: got %0d/%0d expected 3/%0d", db_estado, ini_a, base); end
        reset = 1'b0; #1;
        checks++; if (db_estado !== 4'd0 || vidas !== 2'd0 || nivel !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d/%0d/%0d expected 0/0/0", db_estado, vidas, nivel); end
        checks++; if (periodo !== 8'd50) begin errors++; $display("FAIL mid_reset_periodo: got %0d expected 50", periodo); end
        @(negedge clock); reset = 1'b1; @(negedge clock);
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL mid_reset_idle: got %0d expected 0", db_estado); end
    endtask

    task automatic test_saturation;
        bit ok;
        int exp_p [4] = '{50, 20, 1, 1};
        jogar_b = 1; @(negedge clock); jogar_b = 0;
        for (int r = 0; r < 4; r++) begin
            wait_ini(1'b1, ok);
            checks++; if (!ok || periodo_b !== 8'(exp_p[r])) begin errors++; $display("FAIL sat_periodo: level %0d got %0b/%0d expected 1/%0d", r, ok, periodo_b, exp_p[r]); end
            @(negedge clock);
            venceu_b = 1; @(negedge clock); venceu_b = 0;
        end
        @(negedge clock);
        checks++; if (campeao_b !== 1'b1 || nivel_b !== 2'd3) begin errors++; $display("FAIL sat_campeao: got %0b/%0d expected 1/3", campeao_b, nivel_b); end
    endtask

    initial begin
        test_reset;
        test_win;
        test_loss;
        test_restart;
        test_same_cycle;
        test_held_venceu;
        test_jogar_and_reset;
        test_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
